button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_BTN, default 5, number of push-button channels (up, set, minhr, alarm, change order by index).
REQ-002 Parameter DB_CYC, default 1000000, debounce stability window in clk cycles (10 ms at 100 MHz); legal range 2..2^24-1.
REQ-003 Parameter REP_MASK, default 5'b10000, per-channel auto-repeat enable; bit i set = channel i repeats.
REQ-004 Parameter REP_DLY, default 50000000, cycles from press to first repeat pulse (0.5 s); legal range 2..2^28-1.
REQ-005 Parameter REP_PER, default 20000000, cycles between subsequent repeat pulses (0.2 s); legal range 2..2^28-1.
REQ-006 clk  input  1  100 MHz system clock; all state updates on posedge clk.
REQ-007 clr_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-008 btn_raw  input  N_BTN  asynchronous, bouncing, active-high button levels.
REQ-009 lvl  output  N_BTN  debounced stable level per channel.
REQ-010 press  output  N_BTN  one-cycle pulse on debounced 0->1 transition.
REQ-011 release  output  N_BTN  one-cycle pulse on debounced 1->0 transition.
REQ-012 evt  output  N_BTN  one-cycle pulse = press OR auto-repeat pulse; drives the clock core edge inputs (change, sw, resume, snooze, alarm).

Function
REQ-013 Each channel SHALL pass btn_raw[i] through a 2-flop synchronizer (s1, s2); only s2 feeds later logic.
REQ-014 Each channel SHALL hold a debounce counter of $clog2(DB_CYC) bits, cleared in any cycle where s2 equals lvl.
REQ-015 While s2 differs from lvl the counter SHALL increment; in the cycle it equals DB_CYC-1 lvl SHALL take s2 and the counter SHALL clear.
REQ-016 Latency: btn_raw stable from edge t SHALL appear on lvl at edge t+2+DB_CYC, exact to the cycle.
REQ-017 Any s2 disagreement shorter than DB_CYC cycles SHALL leave lvl, press, release, evt unchanged; a return to agreement restarts the window from zero.
REQ-018 press[i] and release[i] SHALL be registered, asserted exactly in the cycle lvl[i] first shows the new value, for one cycle.
REQ-019 Channels with REP_MASK[i]=1 SHALL run a 3-state FSM: IDLE, DELAY, REPEAT; channels with REP_MASK[i]=0 SHALL stay in IDLE and evt[i]=press[i].
REQ-020 IDLE->DELAY on press[i], loading a 28-bit repeat counter with 0.
REQ-021 DELAY: counter increments each cycle; at REP_DLY-1 emit one repeat pulse, clear counter, go to REPEAT.
REQ-022 REPEAT: counter increments; at REP_PER-1 emit one repeat pulse and clear counter; stay in REPEAT.
REQ-023 Any state ->IDLE in the cycle lvl[i] is 0 (release has priority over a coincident repeat pulse, which SHALL be suppressed).
REQ-024 evt[i] SHALL never assert in two consecutive cycles; press and repeat pulses cannot coincide by construction.
REQ-025 Channels SHALL be fully independent; simultaneous presses on several channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-026 When clr_n=0 at a posedge: s1, s2, lvl, press, release, evt, all counters SHALL be 0 and all FSMs IDLE at the next cycle.
REQ-027 Reset mid-debounce or mid-repeat SHALL abort without any pulse; a button held through reset release SHALL produce press 2+DB_CYC cycles after clr_n rises.
REQ-028 No output SHALL depend combinationally on btn_raw or clr_n.

Verification (DB_CYC=4, REP_DLY=10, REP_PER=3, N_BTN=5)
REQ-029 Clean press: btn_raw[0] 0->1 held at edge 0 -> lvl[0]=1 and press[0]=evt[0]=1 at edge 6 only; release 0->1->0 symmetric with release[0] at edge 6 after drop.
REQ-030 Bounce: btn_raw[1] toggles every 2 cycles for 20 cycles then holds 1 -> no pulse during bounce; single press 6 cycles after final settle.
REQ-031 Auto-repeat: btn_raw[4] held 40 cycles -> evt[4] at press cycle p, then p+10, p+13, p+16, ... until release; no evt after lvl[4]=0.
REQ-032 Release on repeat boundary: lvl[4] drops in the cycle a repeat would fire -> no evt, release[4]=1, FSM IDLE.
REQ-033 Reset mid-operation: clr_n low for 1 cycle during DELAY with button held -> all outputs 0 next cycle; press[4] 6 cycles after clr_n returns high.
REQ-034 Concurrency: btn_raw[0] and btn_raw[2] rise same edge -> press[0], press[2] same cycle; REP_MASK=0 channels never emit extra evt while held.

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button front end: per-channel synchronizer, debouncer, edge pulses and
// an optional auto-repeat FSM that turns a held button into periodic events.
module button_conditioner #(
    parameter int               N_BTN    = 5,
    parameter int               DB_CYC   = 1000000,
    parameter logic [N_BTN-1:0] REP_MASK = N_BTN'(5'b10000),
    parameter int               REP_DLY  = 50000000,
    parameter int               REP_PER  = 20000000
) (
    input  logic               clk_i,
    input  logic               clr_n_i,
    input  logic [N_BTN-1:0]   btn_raw_i,
    output logic [N_BTN-1:0]   lvl_o,
    output logic [N_BTN-1:0]   press_o,
    output logic [N_BTN-1:0]   release_o,
    output logic [N_BTN-1:0]   evt_o,
    output logic [2*N_BTN-1:0] rep_state_o
);

    localparam int              DBW      = $clog2(DB_CYC);
    localparam logic [DBW-1:0]  DB_LAST  = DBW'(DB_CYC - 1);
    localparam logic [27:0]     DLY_LAST = 28'(REP_DLY - 1);
    localparam logic [27:0]     PER_LAST = 28'(REP_PER - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_e;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic           s1_q, s2_q;
        logic           lvl_q, press_q, rel_q, evt_q;
        logic [DBW-1:0] db_cnt_q;
        logic [27:0]    rep_cnt_q;
        rep_state_e     state_q;
        logic           settle, lvl_d, rise, fall;

        // settle marks the edge on which lvl adopts the synchronized input
        always_comb begin
            settle = (s2_q != lvl_q) && (db_cnt_q == DB_LAST);
            lvl_d  = settle ? s2_q : lvl_q;
            rise   = settle & s2_q;
            fall   = settle & ~s2_q;
        end

        always_ff @(posedge clk_i) begin
            if (!clr_n_i) begin
                s1_q     <= 1'b0;
                s2_q     <= 1'b0;
                lvl_q    <= 1'b0;
                press_q  <= 1'b0;
                rel_q    <= 1'b0;
                db_cnt_q <= '0;
            end else begin
                s1_q    <= btn_raw_i[i];
                s2_q    <= s1_q;
                lvl_q   <= lvl_d;
                press_q <= rise;
                rel_q   <= fall;
                if ((s2_q == lvl_q) || settle) begin
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + DBW'(1);
                end
            end
        end

        // Leaving on !lvl_d drops a repeat that would coincide with release
        always_ff @(posedge clk_i) begin
            if (!clr_n_i) begin
                state_q   <= IDLE;
                rep_cnt_q <= '0;
                evt_q     <= 1'b0;
            end else begin
                evt_q     <= rise;
                rep_cnt_q <= '0;
                case (state_q)
                    IDLE: begin
                        if (REP_MASK[i] && rise) begin
                            state_q <= DELAY;
                        end
                    end
                    DELAY: begin
                        if (!lvl_d) begin
                            state_q <= IDLE;
                        end else if (rep_cnt_q == DLY_LAST) begin
                            evt_q   <= 1'b1;
                            state_q <= REPEAT;
                        end else begin
                            rep_cnt_q <= rep_cnt_q + 28'd1;
                        end
                    end
                    REPEAT: begin
                        if (!lvl_d) begin
                            state_q <= IDLE;
                        end else if (rep_cnt_q == PER_LAST) begin
                            evt_q <= 1'b1;
                        end else begin
                            rep_cnt_q <= rep_cnt_q + 28'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end

        assign lvl_o[i]               = lvl_q;
        assign press_o[i]             = press_q;
        assign release_o[i]           = rel_q;
        assign evt_o[i]               = evt_q;
        assign rep_state_o[2*i +: 2]  = state_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short debounce/repeat windows: a per-cycle
// vector table for a clean press, then scoreboarded pulse sequences.
module tb_button_conditioner;
    localparam int N = 5;

    logic           clk = 1'b0;
    logic           clr_n;
    logic [N-1:0]   btn_raw;
    logic [N-1:0]   lvl, press, rel, evt;
    logic [2*N-1:0] rep_state;

    int unsigned    edge_n = 0;
    int             total = 0;
    int             bad = 0;
    logic           mon_en = 1'b0;

    // {edge number, evt, release, press}
    logic [32+3*N-1:0] exp_q[$];

    typedef struct packed {
        logic [N-1:0] raw;
        logic [3:0]   exp;   // lvl, press, release, evt of channel 0
    } vec_t;
    vec_t tbl[18];

    button_conditioner #(
        .N_BTN(N), .DB_CYC(4), .REP_MASK(5'b10000), .REP_DLY(10), .REP_PER(3)
    ) dut (
        .clk_i(clk), .clr_n_i(clr_n), .btn_raw_i(btn_raw),
        .lvl_o(lvl), .press_o(press), .release_o(rel), .evt_o(evt),
        .rep_state_o(rep_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    task automatic goto(input int unsigned t);
        while (edge_n < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int unsigned cyc, input logic [N-1:0] e,
                            input logic [N-1:0] r, input logic [N-1:0] p);
        exp_q.push_back({cyc, e, r, p});
    endtask

    task automatic drain(input string name);
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        logic [3*N-1:0]    obs;
        logic [32+3*N-1:0] e;
        if (mon_en) begin
            obs = {evt, rel, press};
            if (obs != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 64'({edge_n, obs}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse", 64'({edge_n, obs}), 64'(e));
                end
            end
        end
    end

    initial begin
        int unsigned e;
        logic [N-1:0] b;
        logic [19:0] exp20;

        for (int j = 0; j < 18; j++) begin
            tbl[j].raw = (j < 10) ? 5'b00001 : 5'b00000;
            if (j < 5)        tbl[j].exp = 4'b0000;
            else if (j == 5)  tbl[j].exp = 4'b1101;
            else if (j < 15)  tbl[j].exp = 4'b1000;
            else if (j == 15) tbl[j].exp = 4'b0010;
            else              tbl[j].exp = 4'b0000;
        end

        // Reset with random button levels: everything must read zero
        clr_n   = 1'b0;
        btn_raw = 5'($urandom_range(1, 31));
        goto(3);
        @(negedge clk);
        check("reset_outputs", 64'({lvl, press, rel, evt}), 64'd0);
        check("reset_state", 64'(rep_state), 64'd0);
        btn_raw = '0;
        clr_n   = 1'b1;
        goto(12);

        // Clean press/release on channel 0, one vector per cycle
        for (int j = 0; j < 18; j++) begin
            btn_raw = tbl[j].raw;
            goto(edge_n + 1);
            @(negedge clk);
            exp20 = {4'b0, tbl[j].exp[3], 4'b0, tbl[j].exp[2],
                     4'b0, tbl[j].exp[1], 4'b0, tbl[j].exp[0]};
            check($sformatf("table_%0d", j), 64'({lvl, press, rel, evt}), 64'(exp20));
        end
        goto(edge_n + 4);
        mon_en = 1'b1;

        // Bouncing channel 1: toggles every 2 cycles, then settles high
        e = edge_n;
        b = 5'b00010;
        for (int k = 0; k < 10; k++) begin
            goto(e + 2*k);
            btn_raw[1] = (k % 2 == 0);
        end
        goto(e + 20);
        btn_raw[1] = 1'b1;
        push_exp(e + 26, b, '0, b);
        goto(e + 40);
        btn_raw[1] = 1'b0;
        push_exp(e + 46, '0, b, '0);
        goto(e + 52);
        drain("bounce_drain");

        // Auto-repeat on channel 4; release lands on a repeat slot
        e = edge_n;
        b = 5'b10000;
        btn_raw[4] = 1'b1;
        push_exp(e + 6, b, '0, b);
        for (int unsigned t = e + 16; t < e + 46; t += 3) push_exp(t, b, '0, '0);
        push_exp(e + 46, '0, b, '0);
        goto(e + 10);
        @(negedge clk);
        check("rep_delay_state", 64'(rep_state[9:8]), 64'd1);
        goto(e + 40);
        btn_raw[4] = 1'b0;
        goto(e + 45);
        @(negedge clk);
        check("rep_repeat_state", 64'(rep_state[9:8]), 64'd2);
        goto(e + 46);
        @(negedge clk);
        check("rep_idle_after_release", 64'(rep_state[9:8]), 64'd0);
        check("rep_lvl_low", 64'(lvl[4]), 64'd0);
        goto(e + 56);
        drain("repeat_drain");

        // Reset in DELAY with channel 4 held
        e = edge_n;
        btn_raw[4] = 1'b1;
        push_exp(e + 6, b, '0, b);
        push_exp(e + 16, b, '0, b);
        goto(e + 9);
        clr_n = 1'b0;
        goto(e + 10);
        clr_n = 1'b1;
        @(negedge clk);
        check("midreset_outputs", 64'({lvl, press, rel, evt}), 64'd0);
        check("midreset_state", 64'(rep_state), 64'd0);
        goto(e + 20);
        btn_raw[4] = 1'b0;
        push_exp(e + 26, '0, b, '0);
        goto(e + 34);
        drain("midreset_drain");

        // Button held through reset release
        e = edge_n;
        b = 5'b01000;
        clr_n = 1'b0;
        btn_raw[3] = 1'b1;
        goto(e + 2);
        clr_n = 1'b1;
        push_exp(e + 8, b, '0, b);
        goto(e + 15);
        btn_raw[3] = 1'b0;
        push_exp(e + 21, '0, b, '0);
        goto(e + 28);
        drain("held_reset_drain");

        // Channels 0 and 2 together; no repeat while held
        e = edge_n;
        b = 5'b00101;
        btn_raw = b;
        push_exp(e + 6, b, '0, b);
        goto(e + 30);
        btn_raw = '0;
        push_exp(e + 36, '0, b, '0);
        goto(e + 42);
        drain("concurrent_drain");

        // Random clean presses on non-repeating channels
        for (int r = 0; r < 4; r++) begin
            int unsigned ch, h;
            ch = $urandom_range(0, 3);
            h  = $urandom_range(8, 20);
            e  = edge_n;
            b  = 5'(1) << ch;
            btn_raw = b;
            push_exp(e + 6, b, '0, b);
            goto(e + h);
            btn_raw = '0;
            push_exp(e + h + 6, '0, b, '0);
            goto(e + h + 12);
            drain($sformatf("random_drain_%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
